uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo_mem.sv | 25 ++
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive FIFO.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   // One received character with the line errors seen while it was being framed
   typedef struct packed {
      logic [UART_DATA_BITS-1:0] data;
      logic                      parity_err;
      logic                      frame_err;
   } rx_entry_t;

   function automatic bit is_pow2(input int unsigned v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Entry storage for uart_rx_fifo: synchronous write, asynchronous read, no reset.
module uart_rx_fifo_mem
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  rx_entry_t                  wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output rx_entry_t                  rdata
);

   rx_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO behind a UART receiver, pushing once per frame-complete rising edge.
// Optional macro UART_RX_FIFO_ERR_DROP_EN: drop characters with parity/frame errors.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = UART_DATA_BITS,
   parameter int unsigned DEPTH     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_BITS-1:0]     rx_data,
   input  logic                     rx_data_ready,
   input  logic                     rx_parity_err,
   input  logic                     rx_frame_err,
   output logic [DATA_BITS-1:0]     rd_data,
   output logic                     rd_parity_err,
   output logic                     rd_frame_err,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   input  logic                     overflow_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $fatal(1, "uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
   end
   if (DATA_BITS > UART_DATA_BITS || DATA_BITS == 0) begin : g_bad_width
      $fatal(1, "uart_rx_fifo: DATA_BITS must be 1..UART_DATA_BITS");
   end

   logic          rdy_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_nxt;
   logic [AW-1:0] rd_ptr_q, rd_ptr_nxt;
   logic [CW-1:0] count_q, count_nxt;
   logic          full_q, full_nxt;
   logic          empty_q, empty_nxt;
   logic          valid_q, valid_nxt;
   logic          ovf_q, ovf_nxt;

   logic          push_req;
   logic          push_cand;
   logic          push;
   logic          pop;
   logic          discard;
   rx_entry_t     wr_entry;
   rx_entry_t     rd_entry;

   assign push_req = rx_data_ready & ~rdy_q;

`ifdef UART_RX_FIFO_ERR_DROP_EN
   // Errored characters are filtered before the full check so they never count as lost
   assign push_cand = push_req & ~(rx_parity_err | rx_frame_err);

   always_comb begin
      wr_entry            = '0;
      wr_entry.data       = UART_DATA_BITS'(rx_data);
      wr_entry.parity_err = 1'b0;
      wr_entry.frame_err  = 1'b0;
   end

   assign rd_parity_err = 1'b0;
   assign rd_frame_err  = 1'b0;
`else
   assign push_cand = push_req;

   always_comb begin
      wr_entry            = '0;
      wr_entry.data       = UART_DATA_BITS'(rx_data);
      wr_entry.parity_err = rx_parity_err;
      wr_entry.frame_err  = rx_frame_err;
   end

   assign rd_parity_err = rd_entry.parity_err;
   assign rd_frame_err  = rd_entry.frame_err;
`endif

   assign rd_data = DATA_BITS'(rd_entry.data);

   uart_rx_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   // Next-state: a pop frees the slot a full-FIFO push needs in the same cycle
   always_comb begin
      pop        = ~empty_q & rd_ready;
      push       = push_cand & (~full_q | pop);
      discard    = push_cand & full_q & ~pop;
      wr_ptr_nxt = wr_ptr_q;
      rd_ptr_nxt = rd_ptr_q;
      ovf_nxt    = ovf_q;

      if (push) begin
         wr_ptr_nxt = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_nxt = rd_ptr_q + AW'(1);
      end

      count_nxt = count_q + CW'(push) - CW'(pop);
      full_nxt  = (count_nxt == CW'(DEPTH));
      empty_nxt = (count_nxt == '0);
      valid_nxt = ~empty_nxt;

      if (discard) begin
         ovf_nxt = 1'b1;
      end else if (overflow_clr) begin
         ovf_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         rdy_q    <= rx_data_ready;
         wr_ptr_q <= wr_ptr_nxt;
         rd_ptr_q <= rd_ptr_nxt;
         count_q  <= count_nxt;
         full_q   <= full_nxt;
         empty_q  <= empty_nxt;
         valid_q  <= valid_nxt;
         ovf_q    <= ovf_nxt;
      end
   end

   assign count    = count_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign rd_valid = valid_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed, table-driven bench for uart_rx_fifo (default DATA_BITS=8, DEPTH=16).
module tb_uart_rx_fifo;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_data_ready;
   logic       rx_parity_err;
   logic       rx_frame_err;
   logic [7:0] rd_data;
   logic       rd_parity_err;
   logic       rd_frame_err;
   logic       rd_valid;
   logic       rd_ready;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       overflow_clr;

   int checks   = 0;
   int failures = 0;

`ifdef UART_RX_FIFO_ERR_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   uart_rx_fifo dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_data_ready (rx_data_ready),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .rd_data       (rd_data),
      .rd_parity_err (rd_parity_err),
      .rd_frame_err  (rd_frame_err),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .overflow      (overflow),
      .overflow_clr  (overflow_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rdy;
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       rr;
      logic       clr;
      int         exp_count;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic rdy, input logic [7:0] data, input logic perr,
                          input logic ferr, input logic rr, input logic clr,
                          input int exp_count, input logic [7:0] exp_data,
                          input logic exp_perr, input logic exp_ferr, input logic exp_ovf);
      vec_t v;
      v.rdy = rdy; v.data = data; v.perr = perr; v.ferr = ferr; v.rr = rr; v.clr = clr;
      v.exp_count = exp_count; v.exp_data = exp_data;
      v.exp_perr = exp_perr; v.exp_ferr = exp_ferr; v.exp_ovf = exp_ovf;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Check the status outputs against an expected occupancy and overflow
   task automatic chk_status(input string name, input int exp_count, input logic exp_ovf);
      chk({name, ".count"},    int'(count),    exp_count);
      chk({name, ".rd_valid"}, int'(rd_valid), int'(exp_count != 0));
      chk({name, ".empty"},    int'(empty),    int'(exp_count == 0));
      chk({name, ".full"},     int'(full),     int'(exp_count == 16));
      chk({name, ".overflow"}, int'(overflow), int'(exp_ovf));
   endtask

   task automatic step(input logic rdy, input logic [7:0] d, input logic pe, input logic fe,
                       input logic rr, input logic clr);
      @(negedge clk);
      rx_data_ready = rdy;
      rx_data       = d;
      rx_parity_err = pe;
      rx_frame_err  = fe;
      rd_ready      = rr;
      overflow_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic push_char(input logic [7:0] d, input logic rr);
      step(1'b1, d, 1'b0, 1'b0, rr, 1'b0);
      step(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset         = 1'b1;
      rx_data       = '0;
      rx_data_ready = 1'b0;
      rx_parity_err = 1'b0;
      rx_frame_err  = 1'b0;
      rd_ready      = 1'b0;
      overflow_clr  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Table: level held high, error flags, empty-pop, push into empty
      for (int i = 0; i < 16; i++) begin
         add_vec(1, 8'h41, 0, 0, 0, 0, 1, 8'h41, 0, 0, 0);
      end
      add_vec(0, 8'h00, 0, 0, 0, 0, 1, 8'h41, 0, 0, 0);
      if (DROP) begin
         add_vec(1, 8'h7E, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
         add_vec(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
         add_vec(1, 8'h3C, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
         add_vec(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
      end else begin
         add_vec(1, 8'h7E, 0, 1, 1, 0, 1, 8'h7E, 0, 1, 0);
         add_vec(0, 8'h00, 0, 0, 0, 0, 1, 8'h7E, 0, 1, 0);
         add_vec(1, 8'h3C, 1, 0, 0, 0, 2, 8'h7E, 0, 1, 0);
         add_vec(0, 8'h00, 0, 0, 1, 0, 1, 8'h3C, 1, 0, 0);
      end
      add_vec(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
      add_vec(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
      add_vec(1, 8'hA5, 0, 0, 1, 0, 1, 8'hA5, 0, 0, 0);
      add_vec(0, 8'h00, 0, 0, 0, 1, 1, 8'hA5, 0, 0, 0);

      reset = 1'b1;
      do_reset();
      chk_status("reset", 0, 1'b0);

      foreach (vecs[i]) begin
         step(vecs[i].rdy, vecs[i].data, vecs[i].perr, vecs[i].ferr, vecs[i].rr, vecs[i].clr);
         chk_status($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_ovf);
         if (vecs[i].exp_count != 0) begin
            chk($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(vecs[i].exp_data));
            chk($sformatf("vec%0d.rd_parity_err", i), int'(rd_parity_err), int'(vecs[i].exp_perr));
            chk($sformatf("vec%0d.rd_frame_err", i), int'(rd_frame_err), int'(vecs[i].exp_ferr));
         end
      end

      // Fill, overflow, clear, full push+pop, drain
      do_reset();
      for (int i = 0; i < 16; i++) push_char(8'(i), 1'b0);
      chk_status("filled", 16, 1'b0);
      chk("filled.head", int'(rd_data), 8'h00);
      push_char(8'h10, 1'b0);
      chk_status("discard", 16, 1'b1);
      chk("discard.head", int'(rd_data), 8'h00);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_status("ovf_clr", 16, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_status("full_push_pop", 16, 1'b0);
      chk("full_push_pop.head", int'(rd_data), 8'h01);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("drain%0d.head", i), int'(rd_data), i);
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("drain.tail", int'(rd_data), 8'h55);
      chk_status("drain.pre_last", 1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_status("drained", 0, 1'b0);

      // Reset mid-transfer with overflow set, then level already high at release
      for (int i = 0; i < 16; i++) push_char(8'(8'h60 + i), 1'b0);
      push_char(8'hEE, 1'b0);
      for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_status("pre_reset", 5, 1'b1);
      chk("pre_reset.head", int'(rd_data), 8'h6B);
      @(negedge clk);
      rd_ready      = 1'b0;
      rx_data_ready = 1'b1;
      rx_data       = 8'h22;
      #1 reset = 1'b1;
      #1;
      chk_status("async_reset", 0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_status("reset_release", 0, 1'b0);
      @(posedge clk);
      #1;
      chk_status("level_at_release", 1, 1'b0);
      chk("level_at_release.head", int'(rd_data), 8'h22);
      step(1'b1, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_status("level_held", 1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      // overflow_clr coinciding with a discard: set wins
      for (int i = 0; i < 15; i++) push_char(8'(8'h30 + i), 1'b0);
      chk_status("refill", 16, 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_status("clr_vs_discard", 16, 1'b1);
      chk("clr_vs_discard.head", int'(rd_data), 8'h22);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_status("clr_after", 16, 1'b0);

      // Streaming at occupancy 1: pointers wrap several times
      do_reset();
      push_char(8'h80, 1'b0);
      chk("stream.first", int'(rd_data), 8'h80);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 8'(8'h81 + i), 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("stream%0d.count", i), int'(count), 1);
         chk($sformatf("stream%0d.head", i), int'(rd_data), 8'h81 + i);
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk_status("stream.end", 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
